// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------+
// | mem_pkg : shared types and constants for the memory arbiter          |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    IFU = 1'b0,
    LSU = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
// +----------------------------------------------------------------------+
// | rr_arb2 : two-input round-robin picker remembering the last owner    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_req_ifu,
  input  logic   i_req_lsu,
  input  logic   i_accept,
  output owner_e o_grant
);

  owner_e r_last;
  owner_e w_pref;

  // With no conflict the lone requester wins; otherwise the side not served last.
  always_comb begin
    w_pref = (r_last == LSU) ? IFU : LSU;
    if (i_req_ifu && !i_req_lsu)
      o_grant = IFU;
    else if (i_req_lsu && !i_req_ifu)
      o_grant = LSU;
    else
      o_grant = w_pref;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_last <= LSU;
    else if (i_accept)
      r_last <= o_grant;
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter : shares one memory port between fetch and load/store    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_resp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             r_state;
  owner_e             r_owner;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_wen;
  logic [DATA_W-1:0]  r_wdata;
  logic [MASK_W-1:0]  r_wmask;
  logic               r_mem_req_valid;
  logic [CNT_W-1:0]   r_cnt;

  owner_e             w_grant;
  logic               w_idle;
  logic               w_accept;
  logic               w_timeout;
  logic               w_resp;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .i_req_ifu (ifu_req_valid),
    .i_req_lsu (lsu_req_valid),
    .i_accept  (w_accept),
    .o_grant   (w_grant)
  );

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign w_idle        = reset && (r_state == IDLE);
  assign ifu_req_ready = w_idle && (w_grant == IFU);
  assign lsu_req_ready = w_idle && (w_grant == LSU);
  assign w_accept      = (ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready);

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));
  assign w_resp    = (r_state == RESP) && (mem_resp_valid || w_timeout);

  assign ifu_resp_valid = w_resp && (r_owner == IFU);
  assign lsu_resp_valid = w_resp && (r_owner == LSU);
  assign ifu_rdata      = (ifu_resp_valid && mem_resp_valid) ? mem_rdata : '0;
  assign lsu_rdata      = (lsu_resp_valid && mem_resp_valid) ? mem_rdata : '0;
  assign ifu_resp_err   = ifu_resp_valid && !mem_resp_valid;
  assign lsu_resp_err   = lsu_resp_valid && !mem_resp_valid;

  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_owner         <= IFU;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_wdata         <= '0;
      r_wmask         <= '0;
      r_mem_req_valid <= 1'b0;
      r_cnt           <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner         <= w_grant;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
            if (w_grant == LSU) begin
              r_addr  <= lsu_addr;
              r_wen   <= lsu_wen;
              r_wdata <= lsu_wdata;
              r_wmask <= lsu_wmask;
            end else begin
              r_addr  <= ifu_addr;
              r_wen   <= 1'b0;
              r_wdata <= '0;
              r_wmask <= '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= RESP;
          end
        end
        RESP: begin
          // A response arriving on the expiry cycle still completes normally.
          if (mem_resp_valid || w_timeout)
            r_state <= IDLE;
          else
            r_cnt <= r_cnt + CNT_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench for mem_arbiter                    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        lsu_wen = 1'b0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    bit          side;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .ifu_resp_err   (ifu_resp_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .lsu_resp_err   (lsu_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (ifu_resp_valid || lsu_resp_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 128'd1, 128'd0);
        end else begin
          exp_t e;
          logic [127:0] w;
          e = sb.pop_front();
          if (e.side) w = {60'b0, 1'b0, 1'b1, 32'h0, e.rdata, 1'b0, e.err};
          else        w = {60'b0, 1'b1, 1'b0, e.rdata, 32'h0, e.err, 1'b0};
          check("sb_resp", {60'b0, ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata,
                            ifu_resp_err, lsu_resp_err}, w);
        end
      end else begin
        check("quiet", {62'b0, ifu_rdata, lsu_rdata, ifu_resp_err, lsu_resp_err}, 128'd0);
      end
    end
  end

  task automatic accept(input bit side, input string tag);
    @(negedge clk);
    check({tag, "_grant"}, {126'b0, ifu_req_ready, lsu_req_ready}, side ? 128'd1 : 128'd2);
    step();
  endtask

  // Called in the first REQ cycle; rsp_dly < 0 means memory never answers.
  task automatic serve(input bit side, input logic [31:0] addr, input bit wen,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                       input string tag);
    logic [127:0] exp_mem;
    exp_t e;
    bit fire;
    if (side) exp_mem = {58'b0, 1'b1, addr, wen, wdata, wmask};
    else      exp_mem = {58'b0, 1'b1, addr, 1'b0, 32'h0, 4'h0};
    for (int i = 0; i < rdy_dly; i++) begin
      mem_rdata = $urandom;
      @(negedge clk);
      check({tag, "_hold"}, {58'b0, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask}, exp_mem);
      step();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    check({tag, "_memreq"}, {58'b0, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask}, exp_mem);
    check({tag, "_busy"}, {126'b0, ifu_req_ready, lsu_req_ready}, 128'd0);
    e.side  = side;
    e.err   = (rsp_dly < 0);
    e.rdata = (rsp_dly < 0) ? 32'h0 : rdata;
    sb.push_back(e);
    step();
    mem_req_ready = 1'b0;
    for (int k = 0; k <= TMO; k++) begin
      fire = (k == rsp_dly) || (rsp_dly < 0 && k == TMO);
      if (k == rsp_dly) begin
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
      end else begin
        mem_rdata = $urandom;
      end
      @(negedge clk);
      if (k == 0) check({tag, "_reqdrop"}, {127'b0, mem_req_valid}, 128'd0);
      check({tag, "_rv"}, {127'b0, side ? lsu_resp_valid : ifu_resp_valid}, {127'b0, fire});
      step();
      mem_resp_valid = 1'b0;
      if (fire) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctl", {125'b0, ifu_req_ready, lsu_req_ready, mem_req_valid}, 128'd0);
    check("rst_mem", {59'b0, mem_addr, mem_wen, mem_wdata, mem_wmask}, 128'd0);
    check("rst_resp", {60'b0, ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata,
                       ifu_resp_err, lsu_resp_err}, 128'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    ifu_addr  = 32'h8000_0040;
    lsu_addr  = 32'h8000_2000;
    lsu_wdata = 32'h1111_2222;
    lsu_wmask = 4'hF;

    // round-robin: IFU, then LSU, then IFU
    accept(1'b0, "rr1");
    ifu_req_valid = 1'b0;
    serve(1'b0, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 0, 0, 32'hA0A0_0001, "rr1");
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0080;
    accept(1'b1, "rr2");
    lsu_req_valid = 1'b0;
    serve(1'b1, 32'h8000_2000, 1'b0, 32'h1111_2222, 4'hF, 1, 1, 32'hB0B0_0002, "rr2");
    lsu_req_valid = 1'b1;
    accept(1'b0, "rr3");
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    serve(1'b0, 32'h8000_0080, 1'b0, 32'h0, 4'h0, 0, 2, 32'hC0C0_0003, "rr3");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("no_issue", {127'b0, mem_req_valid}, 128'd0);
      step();
    end

    // fetch at minimum latency, followed immediately by a store
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    accept(1'b0, "ifu");
    ifu_req_valid = 1'b0;
    serve(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_0413, "ifu");
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 4'h3;
    accept(1'b1, "st");
    lsu_req_valid = 1'b0;
    lsu_wdata     = 32'h0;
    serve(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3, 3, 0, 32'h5A5A_0000, "st");

    // timeout and the simultaneous-response boundary
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0100;
    accept(1'b0, "tmo");
    ifu_req_valid = 1'b0;
    serve(1'b0, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 0, -1, 32'h0, "tmo");
    @(negedge clk);
    check("tmo_idle", {127'b0, ifu_req_ready | lsu_req_ready}, 128'd1);
    step();
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_3000;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 4'h0;
    accept(1'b1, "tmo_edge");
    lsu_req_valid = 1'b0;
    serve(1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 0, TMO, 32'h1234_5678, "tmo_edge");

    // reset while a fetch sits in RESP
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0200;
    accept(1'b0, "rst_mid");
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_out", {59'b0, mem_req_valid, mem_addr, ifu_resp_valid, lsu_resp_valid,
                          ifu_req_ready, lsu_req_ready}, 128'd0);
    step();
    reset          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hFEED_F00D;
    @(negedge clk);
    check("rst_mid_noresp", {126'b0, ifu_resp_valid, lsu_resp_valid}, 128'd0);
    step();
    mem_resp_valid = 1'b0;
    lsu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_4000;
    lsu_wen        = 1'b1;
    lsu_wdata      = 32'h0BAD_CAFE;
    lsu_wmask      = 4'hC;
    accept(1'b1, "post_rst");
    lsu_req_valid = 1'b0;
    serve(1'b1, 32'h8000_4000, 1'b1, 32'h0BAD_CAFE, 4'hC, 1, 1, 32'h7777_8888, "post_rst");

    // stray memory response while idle
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h9999_AAAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stray", {125'b0, ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 128'd0);
      step();
    end
    mem_resp_valid = 1'b0;

    step();
    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
